// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline definitions: the zig-zag reorder table and the
// ping-pong bank state used by the inverse zig-zag block.
package jpeg_pkg;

    localparam int BLOCK_BEATS = 64;

    // Entry n is the zig-zag position of coefficient n = 8*column + row.
    localparam logic [5:0] ZZ_IDX [0:63] = '{
        6'd0,  6'd2,  6'd3,  6'd9,  6'd10, 6'd20, 6'd21, 6'd35,
        6'd1,  6'd4,  6'd8,  6'd11, 6'd19, 6'd22, 6'd34, 6'd36,
        6'd5,  6'd7,  6'd12, 6'd18, 6'd23, 6'd33, 6'd37, 6'd48,
        6'd6,  6'd13, 6'd17, 6'd24, 6'd32, 6'd38, 6'd47, 6'd49,
        6'd14, 6'd16, 6'd25, 6'd31, 6'd39, 6'd46, 6'd50, 6'd57,
        6'd15, 6'd26, 6'd30, 6'd40, 6'd45, 6'd51, 6'd56, 6'd58,
        6'd27, 6'd29, 6'd41, 6'd44, 6'd52, 6'd55, 6'd59, 6'd62,
        6'd28, 6'd42, 6'd43, 6'd53, 6'd54, 6'd60, 6'd61, 6'd63
    };

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    function automatic int tdataWidth(input int width);
        return ((width + 7) / 8) * 8;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with a single-bit tuser; master drives the payload,
// slave drives tready.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tuser;
    logic                    tlast;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tuser, tlast,
        output tready
    );

endinterface

// File: rtl/inv_zz_bank.sv
// One 64-coefficient storage bank: sequential write port, combinational
// indexed read port. Contents are deliberately not reset.
module inv_zz_bank
    import jpeg_pkg::*;
#(
    parameter int DCT_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 wrEn_i,
    input  logic [5:0]           wrIdx_i,
    input  logic [DCT_WIDTH-1:0] wrData_i,
    input  logic [5:0]           rdIdx_i,
    output logic [DCT_WIDTH-1:0] rdData_o
);

    logic [DCT_WIDTH-1:0] mem_q [BLOCK_BEATS];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrIdx_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdIdx_i];

endmodule

// File: rtl/inv_zig_zag.sv
// Inverse zig-zag reorder: 64-beat zig-zag blocks in, column-major blocks out,
// through a ping-pong bank pair. Define INV_ZIG_ZAG_ERR_EN to add err_o.
module inv_zig_zag
    import jpeg_pkg::*;
#(
    parameter int DCT_WIDTH = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  zz_i,
    axi4_stream_if.master dct_o
`ifdef INV_ZIG_ZAG_ERR_EN
    ,
    output logic          err_o
`endif
);

    localparam int DCT_TDATA_WIDTH = tdataWidth(DCT_WIDTH);

    logic [5:0]           wrIdx_q, wrIdx_d;
    logic [5:0]           rdIdx_q, rdIdx_d;
    logic                 wrBank_q, wrBank_d;
    logic                 rdBank_q, rdBank_d;
    bank_state_t          bankState_q [2];
    bank_state_t          bankState_d [2];
    logic [1:0]           tuserFlag_q, tuserFlag_d;
    logic [1:0]           tlastFlag_q, tlastFlag_d;
    logic                 valid_q, valid_d;

    logic                 wrFire, wrDone;
    logic                 rdFire, rdDone;
    logic [5:0]           rdAddr;
    logic [DCT_WIDTH-1:0] rdData0, rdData1, rdData;
    logic                 unusedZz;

    assign rdFire = valid_q & dct_o.tready;
    assign rdDone = rdFire & (rdIdx_q == 6'd63);

    // A bank whose last beat is leaving this cycle can already take the first
    // beat of the next block; that is what keeps back-to-back blocks gap-free.
    assign zz_i.tready = (bankState_q[wrBank_q] == EMPTY)
                       | (rdDone & (rdBank_q == wrBank_q));
    assign wrFire = zz_i.tvalid & zz_i.tready;
    assign wrDone = wrFire & (wrIdx_q == 6'd63);

    assign rdAddr = ZZ_IDX[rdIdx_q];

    inv_zz_bank #(.DCT_WIDTH(DCT_WIDTH)) u_bank0 (
        .clk_i    (clk_i),
        .wrEn_i   (wrFire & ~wrBank_q),
        .wrIdx_i  (wrIdx_q),
        .wrData_i (zz_i.tdata[DCT_WIDTH-1:0]),
        .rdIdx_i  (rdAddr),
        .rdData_o (rdData0)
    );

    inv_zz_bank #(.DCT_WIDTH(DCT_WIDTH)) u_bank1 (
        .clk_i    (clk_i),
        .wrEn_i   (wrFire & wrBank_q),
        .wrIdx_i  (wrIdx_q),
        .wrData_i (zz_i.tdata[DCT_WIDTH-1:0]),
        .rdIdx_i  (rdAddr),
        .rdData_o (rdData1)
    );

    always_comb begin
        wrIdx_d     = wrIdx_q;
        rdIdx_d     = rdIdx_q;
        wrBank_d    = wrBank_q;
        rdBank_d    = rdBank_q;
        bankState_d = bankState_q;
        tuserFlag_d = tuserFlag_q;
        tlastFlag_d = tlastFlag_q;

        // Beat 0 restarts the per-block side-band flags; later beats accumulate.
        if (wrFire) begin
            wrIdx_d = wrIdx_q + 6'd1;
            tuserFlag_d[wrBank_q] = zz_i.tuser | ((wrIdx_q != 6'd0) & tuserFlag_q[wrBank_q]);
            tlastFlag_d[wrBank_q] = zz_i.tlast | ((wrIdx_q != 6'd0) & tlastFlag_q[wrBank_q]);
        end
        if (wrDone) begin
            wrBank_d = ~wrBank_q;
        end

        if (rdFire) begin
            rdIdx_d = rdIdx_q + 6'd1;
        end
        if (rdDone) begin
            rdBank_d              = ~rdBank_q;
            bankState_d[rdBank_q] = EMPTY;
        end
        if (wrDone) begin
            bankState_d[wrBank_q] = FULL;
        end

        valid_d = (bankState_d[rdBank_d] == FULL);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wrIdx_q        <= '0;
            rdIdx_q        <= '0;
            wrBank_q       <= 1'b0;
            rdBank_q       <= 1'b0;
            bankState_q[0] <= EMPTY;
            bankState_q[1] <= EMPTY;
            tuserFlag_q    <= '0;
            tlastFlag_q    <= '0;
            valid_q        <= 1'b0;
        end else begin
            wrIdx_q     <= wrIdx_d;
            rdIdx_q     <= rdIdx_d;
            wrBank_q    <= wrBank_d;
            rdBank_q    <= rdBank_d;
            bankState_q <= bankState_d;
            tuserFlag_q <= tuserFlag_d;
            tlastFlag_q <= tlastFlag_d;
            valid_q     <= valid_d;
        end
    end

    assign rdData       = rdBank_q ? rdData1 : rdData0;
    assign dct_o.tvalid = valid_q;
    assign dct_o.tdata  = DCT_TDATA_WIDTH'(rdData);
    assign dct_o.tstrb  = '1;
    assign dct_o.tkeep  = '1;
    assign dct_o.tuser  = tuserFlag_q[rdBank_q] & (rdIdx_q == 6'd0)  & valid_q;
    assign dct_o.tlast  = tlastFlag_q[rdBank_q] & (rdIdx_q == 6'd63) & valid_q;

    assign unusedZz = ^{zz_i.tdata, zz_i.tstrb, zz_i.tkeep};

`ifdef INV_ZIG_ZAG_ERR_EN
    logic err_q, err_d;

    // Side-band markers are only legal on the first (tuser) and last (tlast) beat.
    always_comb begin
        err_d = err_q;
        if (wrFire && ((zz_i.tlast && (wrIdx_q != 6'd63)) ||
                       (zz_i.tuser && (wrIdx_q != 6'd0)))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_inv_zig_zag.sv
// Directed bench for inv_zig_zag; adds the framing-error test when
// INV_ZIG_ZAG_ERR_EN is defined.
module tb_inv_zig_zag;

    localparam int DCT_WIDTH = 12;
    localparam int TW        = 16;

    // Zig-zag position of each raster (row*8 + col) coefficient.
    localparam int RASTER [0:63] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

    typedef struct {
        int            beat;
        logic [TW-1:0] expData;
        logic          expUser;
        logic          expLast;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i;

    int checks    = 0;
    int errors    = 0;
    int cycleCnt  = 0;
    int stallErr  = 0;
    int inWaits   = 0;
    int beatsSent = 0;

    logic          stallPrev = 1'b0;
    logic [TW-1:0] stallData = '0;

    logic [TW-1:0] outData  [$];
    logic          outUser  [$];
    logic          outLast  [$];
    int            outCycle [$];

    axi4_stream_if #(.DATA_WIDTH(TW)) zzIf ();
    axi4_stream_if #(.DATA_WIDTH(TW)) dctIf ();

`ifdef INV_ZIG_ZAG_ERR_EN
    logic errO;
`endif

    inv_zig_zag #(.DCT_WIDTH(DCT_WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .zz_i  (zzIf),
        .dct_o (dctIf)
`ifdef INV_ZIG_ZAG_ERR_EN
        ,
        .err_o (errO)
`endif
    );

    always #5 clk = ~clk;

    // Output capture on the falling edge; a beat seen valid&ready here is
    // consumed at the following rising edge.
    always @(negedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (dctIf.tvalid === 1'b1 && dctIf.tready === 1'b1) begin
            outData.push_back(dctIf.tdata);
            outUser.push_back(dctIf.tuser);
            outLast.push_back(dctIf.tlast);
            outCycle.push_back(cycleCnt);
        end
        if (stallPrev && dctIf.tvalid === 1'b1 && dctIf.tdata !== stallData) begin
            stallErr <= stallErr + 1;
        end
        stallPrev <= (dctIf.tvalid === 1'b1) && (dctIf.tready === 1'b0);
        stallData <= dctIf.tdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idle();
        zzIf.tvalid = 1'b0;
        zzIf.tuser  = 1'b0;
        zzIf.tlast  = 1'b0;
    endtask

    // Presents one beat and returns one tick after the edge that accepted it.
    task automatic applyStimulus(input logic [TW-1:0] v, input logic u, input logic l);
        int waitCnt;
        waitCnt     = 0;
        zzIf.tvalid = 1'b1;
        zzIf.tdata  = v;
        zzIf.tuser  = u;
        zzIf.tlast  = l;
        @(negedge clk);
        while (zzIf.tready !== 1'b1 && waitCnt < 3000) begin
            @(negedge clk);
            waitCnt++;
        end
        inWaits += waitCnt;
        if (waitCnt >= 3000) begin
            checkOutput("input handshake timeout", waitCnt, 0);
        end
        @(posedge clk);
        #1;
        beatsSent++;
    endtask

    task automatic sendBlock(input int base, input logic userFirst, input logic lastEnd);
        for (int k = 0; k < 64; k++) begin
            applyStimulus(TW'(base + k), userFirst && (k == 0), lastEnd && (k == 63));
        end
    endtask

    task automatic doReset(input logic readyVal);
        idle();
        dctIf.tready = readyVal;
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clearMon();
        outData.delete();
        outUser.delete();
        outLast.delete();
        outCycle.delete();
    endtask

    task automatic waitOutputs(input int n, input string name);
        int cnt;
        cnt = 0;
        while (outData.size() < n && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        repeat (5) @(negedge clk);
        checkOutput(name, outData.size(), n);
    endtask

    task automatic checkBlockData(input int startIdx, input int base, input string name);
        int mism;
        mism = 0;
        for (int n = 0; n < 64; n++) begin
            if (outData.size() <= startIdx + n) begin
                mism++;
            end else if (outData[startIdx + n] !== TW'(base + RASTER[(n % 8) * 8 + n / 8])) begin
                mism++;
            end
        end
        checkOutput(name, mism, 0);
    endtask

    initial begin
        vec_t vecs [14];
        int   userCnt, userPos, lastCnt, lastPos, stallBase;

        vecs[0]  = '{0,  16'd0,  1'b0, 1'b0};
        vecs[1]  = '{1,  16'd2,  1'b0, 1'b0};
        vecs[2]  = '{2,  16'd3,  1'b0, 1'b0};
        vecs[3]  = '{3,  16'd9,  1'b0, 1'b0};
        vecs[4]  = '{4,  16'd10, 1'b0, 1'b0};
        vecs[5]  = '{5,  16'd20, 1'b0, 1'b0};
        vecs[6]  = '{6,  16'd21, 1'b0, 1'b0};
        vecs[7]  = '{7,  16'd35, 1'b0, 1'b0};
        vecs[8]  = '{8,  16'd1,  1'b0, 1'b0};
        vecs[9]  = '{9,  16'd4,  1'b0, 1'b0};
        vecs[10] = '{15, 16'd36, 1'b0, 1'b0};
        vecs[11] = '{56, 16'd28, 1'b0, 1'b0};
        vecs[12] = '{62, 16'd61, 1'b0, 1'b0};
        vecs[13] = '{63, 16'd63, 1'b0, 1'b0};

        rst_i        = 1'b0;
        zzIf.tdata   = '0;
        zzIf.tstrb   = '1;
        zzIf.tkeep   = '1;
        idle();
        dctIf.tready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset tvalid", dctIf.tvalid, 0);
        checkOutput("reset tuser", dctIf.tuser, 0);
        checkOutput("reset tlast", dctIf.tlast, 0);
`ifdef INV_ZIG_ZAG_ERR_EN
        checkOutput("reset err_o", errO, 0);
`endif
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("tready after reset", zzIf.tready, 1);
        @(posedge clk);
        #1;

        // Single block, value k on zig-zag beat k
        $display("[TB] single block reorder");
        clearMon();
        dctIf.tready = 1'b1;
        for (int k = 0; k < 63; k++) begin
            applyStimulus(TW'(k), 1'b0, 1'b0);
        end
        checkOutput("no early tvalid", dctIf.tvalid, 0);
        applyStimulus(TW'(63), 1'b0, 1'b0);
        idle();
        @(negedge clk);
        checkOutput("first beat latency", dctIf.tvalid, 1);
        waitOutputs(64, "single block beat count");
        for (int i = 0; i < 14; i++) begin
            if (outData.size() > vecs[i].beat) begin
                checkOutput($sformatf("vec%0d data beat %0d", i, vecs[i].beat),
                            outData[vecs[i].beat], vecs[i].expData);
                checkOutput($sformatf("vec%0d user/last beat %0d", i, vecs[i].beat),
                            {outUser[vecs[i].beat], outLast[vecs[i].beat]},
                            {vecs[i].expUser, vecs[i].expLast});
            end else begin
                checkOutput($sformatf("vec%0d beat %0d missing", i, vecs[i].beat),
                            outData.size(), vecs[i].beat + 1);
            end
        end

        // Three blocks back to back with downstream always ready
        $display("[TB] back-to-back throughput");
        @(posedge clk);
        #1;
        clearMon();
        inWaits = 0;
        sendBlock(0, 1'b0, 1'b0);
        sendBlock(64, 1'b0, 1'b0);
        sendBlock(128, 1'b0, 1'b0);
        idle();
        waitOutputs(192, "b2b beat count");
        checkOutput("b2b input stalls", inWaits, 0);
        if (outCycle.size() >= 192) begin
            checkOutput("b2b output span", outCycle[191] - outCycle[0], 191);
        end else begin
            checkOutput("b2b output span short", outCycle.size(), 192);
        end
        checkBlockData(0, 0, "b2b block0 data");
        checkBlockData(64, 64, "b2b block1 data");
        checkBlockData(128, 128, "b2b block2 data");

        // Downstream stalled: both banks fill, then everything drains intact
        $display("[TB] backpressure");
        doReset(1'b0);
        clearMon();
        beatsSent = 0;
        stallBase = stallErr;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    applyStimulus(TW'(k), 1'b0, 1'b0);
                end
                idle();
            end
            begin
                int cnt;
                cnt = 0;
                while (beatsSent < 128 && cnt < 1000) begin
                    @(negedge clk);
                    cnt++;
                end
                repeat (10) @(negedge clk);
                checkOutput("beats accepted while stalled", beatsSent, 128);
                checkOutput("tready low with both banks full", zzIf.tready, 0);
                checkOutput("stalled tvalid", dctIf.tvalid, 1);
                checkOutput("stalled tdata", dctIf.tdata, 0);
                @(posedge clk);
                #1;
                dctIf.tready = 1'b1;
            end
        join
        waitOutputs(192, "backpressure beat count");
        checkBlockData(0, 0, "bp block0 data");
        checkBlockData(64, 64, "bp block1 data");
        checkBlockData(128, 128, "bp block2 data");
        checkOutput("tdata stable during stall", stallErr - stallBase, 0);

        // tuser / tlast propagation on the second block only
        $display("[TB] side-band flags");
        doReset(1'b1);
        clearMon();
        sendBlock(256, 1'b0, 1'b0);
        sendBlock(768, 1'b1, 1'b1);
        idle();
        waitOutputs(128, "flag test beat count");
        userCnt = 0; userPos = -1; lastCnt = 0; lastPos = -1;
        for (int i = 0; i < outData.size(); i++) begin
            if (outUser[i] === 1'b1) begin userCnt++; userPos = i; end
            if (outLast[i] === 1'b1) begin lastCnt++; lastPos = i; end
        end
        checkOutput("tuser count", userCnt, 1);
        checkOutput("tuser position", userPos, 64);
        checkOutput("tlast count", lastCnt, 1);
        checkOutput("tlast position", lastPos, 127);
        checkBlockData(64, 768, "flag block data");
`ifdef INV_ZIG_ZAG_ERR_EN
        checkOutput("no err on legal flags", errO, 0);
`endif

        // Reset in the middle of a block, then a fresh block
        $display("[TB] mid-block reset");
        clearMon();
        for (int k = 0; k <= 30; k++) begin
            applyStimulus(TW'(2048 + k), 1'b0, 1'b0);
        end
        doReset(1'b1);
        clearMon();
        sendBlock(1024, 1'b0, 1'b0);
        idle();
        waitOutputs(64, "fresh block beat count");
        checkBlockData(0, 1024, "fresh block data");

`ifdef INV_ZIG_ZAG_ERR_EN
        // Early tlast raises the sticky error
        $display("[TB] framing error");
        doReset(1'b1);
        for (int k = 0; k < 40; k++) begin
            applyStimulus(TW'(k), 1'b0, 1'b0);
        end
        checkOutput("err before bad tlast", errO, 0);
        applyStimulus(TW'(40), 1'b0, 1'b1);
        idle();
        @(negedge clk);
        checkOutput("err rises", errO, 1);
        repeat (20) @(negedge clk);
        checkOutput("err sticky", errO, 1);
        doReset(1'b1);
        @(negedge clk);
        checkOutput("err cleared by reset", errO, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
